// File: rtl/register_file_pkg.sv
// Shared types and default parameter values for the register file and its clear sequencer.
package register_file_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_ZERO_REG = 0;

endpackage

// File: rtl/register_be_r_en.sv
// One DATA_W-wide storage register with async active-low reset and per-byte write enables.
module register_be_r_en
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    q_reg[8*i +: 8] <= d[8*i +: 8];
                end
            end
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_file_np.sv
// Byte-enabled register file: one write port, two write-first combinational read ports,
// and a one-register-per-cycle clear sweep that blocks writes while it runs.
module register_file_np
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = DEF_ZERO_REG,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              idx_last;
    logic              wr_accept;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] rd_addr [2];

    // Out-of-range addresses and the hard-wired zero register are never stored or read.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    assign idx_last = (int'(idx_reg) == DEPTH - 1);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                if (idx_last) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign clr_busy  = (state_reg == SWEEP);
    assign clr_done  = (state_reg == DONE);
    assign wr_ready  = !clr_busy;
    assign wr_accept = we && wr_ready && addr_ok(wr_addr);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic              clr_hit;
            logic              wr_hit;
            logic [BE_W-1:0]   be;
            logic [DATA_W-1:0] d;

            assign clr_hit = clr_busy && (int'(idx_reg) == gi);
            assign wr_hit  = wr_accept && (int'(wr_addr) == gi);
            assign be      = clr_hit ? '1 : (wr_hit ? wr_be : '0);
            assign d       = clr_hit ? '0 : wr_data;

            register_be_r_en #(.DATA_W(DATA_W)) u_reg (
                .clk     (clk),
                .reset_n (reset_n),
                .be      (be),
                .d       (d),
                .q       (regs[gi])
            );
        end
    endgenerate

    // Post-write value of the addressed register, used for write-first bypass.
    always_comb begin
        merged = regs[wr_addr];
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;

            always_comb begin
                data = '0;
                if (addr_ok(rd_addr[gi])) begin
                    data = regs[rd_addr[gi]];
                    if (wr_accept && (wr_addr == rd_addr[gi])) begin
                        data = merged;
                    end
                end
            end
        end
    endgenerate

    assign rd_data0 = g_rd[0].data;
    assign rd_data1 = g_rd[1].data;

endmodule

// File: tb/tb_register_file_np.sv
// Directed bench for register_file_np: default, DEPTH=6 and ZERO_REG=1 instances share one stimulus.
module tb_register_file_np;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr0, rd_addr1;
    logic        clr_req;

    logic        dut_ready, dut_busy, dut_done;
    logic [31:0] dut_rd0, dut_rd1;
    logic        d6_ready, d6_busy, d6_done;
    logic [31:0] d6_rd0, d6_rd1;
    logic        z_ready, z_busy, z_done;
    logic [31:0] z_rd0, z_rd1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    register_file_np u_dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wr_ready(dut_ready),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(dut_rd0), .rd_addr1(rd_addr1), .rd_data1(dut_rd1),
        .clr_req(clr_req), .clr_busy(dut_busy), .clr_done(dut_done)
    );

    register_file_np #(.DEPTH(6)) u_d6 (
        .clk(clk), .reset_n(reset_n), .we(we), .wr_ready(d6_ready),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(d6_rd0), .rd_addr1(rd_addr1), .rd_data1(d6_rd1),
        .clr_req(clr_req), .clr_busy(d6_busy), .clr_done(d6_done)
    );

    register_file_np #(.ZERO_REG(1)) u_z (
        .clk(clk), .reset_n(reset_n), .we(we), .wr_ready(z_ready),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(z_rd0), .rd_addr1(rd_addr1), .rd_data1(z_rd1),
        .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        we = 1'b0;
    endtask

    initial begin
        int busy_cnt, d6_busy_cnt, done_cnt, d6_done_cnt;

        reset_n = 1'b0; we = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_addr0 = 3'd3; rd_addr1 = 3'd0; clr_req = 1'b0;
        @(negedge clk);
        tick();
        check("reset_rd0", dut_rd0, 32'h0);
        check("reset_busy", {31'b0, dut_busy}, 32'h0);
        check("reset_done", {31'b0, dut_done}, 32'h0);
        check("reset_ready", {31'b0, dut_ready}, 32'h1);

        // Release and write at the very first active edge.
        reset_n = 1'b1;
        we = 1'b1; wr_addr = 3'd3; wr_data = 32'hAABBCCDD; wr_be = 4'b1111;
        #1 check("bypass_full", dut_rd0, 32'hAABBCCDD);
        tick();
        wr_data = 32'h11223344; wr_be = 4'b0101;
        #1 check("bypass_merge", dut_rd0, 32'hAA22CC44);
        tick();
        we = 1'b0;
        #1 check("be_merge", dut_rd0, 32'hAA22CC44);
        check("be_merge_d6", d6_rd0, 32'hAA22CC44);

        // Dual-port bypass.
        rd_addr0 = 3'd5; rd_addr1 = 3'd5;
        we = 1'b1; wr_addr = 3'd5; wr_data = 32'h12345678; wr_be = 4'b1111;
        #1 check("dual_bypass0", dut_rd0, 32'h12345678);
        check("dual_bypass1", dut_rd1, 32'h12345678);
        tick();
        we = 1'b0;
        #1 check("dual_hold0", dut_rd0, 32'h12345678);
        check("dual_hold1", dut_rd1, 32'h12345678);

        // Out-of-range address on the DEPTH=6 instance.
        rd_addr0 = 3'd7; rd_addr1 = 3'd5;
        we = 1'b1; wr_addr = 3'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        #1 check("oor_no_bypass_d6", d6_rd0, 32'h0);
        check("inrange_bypass", dut_rd0, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1 check("oor_read_d6", d6_rd0, 32'h0);
        check("oor_no_alias_d6", d6_rd1, 32'h12345678);
        check("addr7_stored", dut_rd0, 32'hDEADBEEF);

        // Hard-wired zero register.
        rd_addr0 = 3'd0;
        we = 1'b1; wr_addr = 3'd0; wr_data = 32'h5; wr_be = 4'b1111;
        #1 check("zreg_no_bypass", z_rd0, 32'h0);
        tick();
        we = 1'b0;
        #1 check("zreg_read", z_rd0, 32'h0);
        check("reg0_normal", dut_rd0, 32'h5);

        // Fill, then sweep; writes to reg 0 attempted throughout the sweep.
        for (int a = 0; a < 8; a++) write(3'(a), 32'hFFFFFFFF, 4'b1111);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        rd_addr0 = 3'd3; rd_addr1 = 3'd4;
        busy_cnt = 0; d6_busy_cnt = 0; done_cnt = 0; d6_done_cnt = 0;
        we = 1'b1; wr_addr = 3'd0; wr_data = 32'h77; wr_be = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (dut_busy) busy_cnt++;
            if (d6_busy) d6_busy_cnt++;
            if (dut_done) done_cnt++;
            if (d6_done) d6_done_cnt++;
            if (c == 4) begin
                check("sweep_cleared", dut_rd0, 32'h0);
                check("sweep_pending", dut_rd1, 32'hFFFFFFFF);
                check("sweep_ready", {31'b0, dut_ready}, 32'h0);
            end
            we = dut_busy;
            tick();
        end
        we = 1'b0;
        check("busy_cycles", busy_cnt, 32'd8);
        check("busy_cycles_d6", d6_busy_cnt, 32'd6);
        check("done_pulses", done_cnt, 32'd1);
        check("done_pulses_d6", d6_done_cnt, 32'd1);
        for (int a = 0; a < 8; a++) begin
            rd_addr0 = 3'(a);
            #1 check($sformatf("cleared_%0d", a), dut_rd0, 32'h0);
        end

        // Reset in the middle of a sweep.
        write(3'd2, 32'hAAAA5555, 4'b1111);
        write(3'd6, 32'h00001234, 4'b1111);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        rd_addr0 = 3'd6; rd_addr1 = 3'd2;
        #1 check("rst_mid_rd6", dut_rd0, 32'h0);
        check("rst_mid_rd2", dut_rd1, 32'h0);
        check("rst_mid_busy", {31'b0, dut_busy}, 32'h0);
        check("rst_mid_ready", {31'b0, dut_ready}, 32'h1);
        tick();
        reset_n = 1'b1;
        write(3'd2, 32'h9, 4'b1111);
        #1 check("post_rst_write", dut_rd1, 32'h9);
        check("post_rst_rd6", dut_rd0, 32'h0);
        check("post_rst_idle", {31'b0, dut_busy}, 32'h0);
        check("post_rst_done", {31'b0, dut_done}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file_np.md
REGISTER_FILE_NP -- requirements
Module: register_file_np

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data width in bits; legal values are multiples of 8 and at least 8.
REQ-002 SHALL provide parameter DEPTH, default 8, register count; legal range is 2..256, and DEPTH need not be a power of two.
REQ-003 SHALL provide parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL derive localparam ADDR_W = $clog2(DEPTH) and BE_W = DATA_W/8.
REQ-005 SHALL have ports (name, direction, width, meaning):
  clk        in   1       single clock, rising edge
  reset_n    in   1       asynchronous, active-low reset
  we         in   1       write request
  wr_ready   out  1       write port can accept; equals !clr_busy
  wr_addr    in   ADDR_W  write address
  wr_be      in   BE_W    byte enables; bit i covers wr_data[8i+7:8i]
  wr_data    in   DATA_W  write data
  rd_addr0   in   ADDR_W  read port 0 address
  rd_data0   out  DATA_W  read port 0 data
  rd_addr1   in   ADDR_W  read port 1 address
  rd_data1   out  DATA_W  read port 1 data
  clr_req    in   1       request a sequential clear of all registers
  clr_busy   out  1       clear sweep in progress
  clr_done   out  1       one-cycle pulse when the sweep completes

Function
REQ-006 A write SHALL be accepted when we=1 and wr_ready=1 at a rising clk edge; each byte with wr_be[i]=1 updates, and other bytes hold.
REQ-007 A write with we=1 and wr_ready=0 SHALL be dropped with no side effect.
REQ-008 A write to wr_addr >= DEPTH, or to address 0 when ZERO_REG=1, SHALL be dropped.
REQ-009 Reads SHALL be combinational (zero latency): rd_dataN = register[rd_addrN].
REQ-010 Read bypass SHALL apply: when a write is being accepted in the current cycle to the same address as rd_addrN, rd_dataN shows the byte-merged post-write value (write-first).
REQ-011 rd_dataN SHALL be 0 when rd_addrN >= DEPTH, or when rd_addrN=0 and ZERO_REG=1; bypass does not override this.
REQ-012 The clear FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-013 IDLE -> SWEEP SHALL occur on clr_req=1; the sweep index is loaded with 0 and clr_busy=1 from the next cycle.
REQ-014 In SWEEP, one register per cycle SHALL be written to all-zero, at index 0..DEPTH-1 ascending.
REQ-015 After index DEPTH-1 is cleared the FSM SHALL go to DONE; DONE asserts clr_done=1 and clr_busy=0 for one cycle, then returns to IDLE.
REQ-016 A full sweep SHALL take exactly DEPTH cycles with clr_busy=1.
REQ-017 clr_req SHALL be ignored while in SWEEP or DONE; a held clr_req starts a new sweep from IDLE.
REQ-018 If we=1 and clr_req=1 arrive in the same IDLE cycle, the write SHALL be accepted (wr_ready is still 1) and then cleared by the sweep.
REQ-019 Reads during SWEEP SHALL return current contents: already-cleared registers read 0, the rest read old values, and there is no bypass of the clear write.
REQ-020 The sweep index SHALL be ADDR_W bits wide and SHALL NOT wrap; termination compares against DEPTH-1, so a non-power-of-two DEPTH never touches out-of-range indices.

Reset
REQ-021 While reset_n=0, all registers SHALL be 0, FSM=IDLE, sweep index=0, clr_busy=0, clr_done=0 and wr_ready=1.
REQ-022 Reset asserted mid-sweep SHALL abort the sweep immediately, with every register cleared regardless of progress.
REQ-023 On reset release, the first write SHALL be accepted at the first rising edge with reset_n=1.

Structure
REQ-024 A shared package register_file_pkg SHALL hold the clear FSM state enum clr_state_t {IDLE, SWEEP, DONE} and default parameter constants.
REQ-025 One sub-module, register_be_r_en, SHALL implement a single DATA_W register with async active-low reset and per-byte enable; it is instantiated DEPTH times via generate.
REQ-026 Write-decode, bypass and clear logic SHALL live in the top module.

Verification
REQ-027 Byte-enable write: reset, then write addr 3, data 0xAABBCCDD, be 1111; then write addr 3, data 0x11223344, be 0101 -> rd_data0(addr 3) = 0xAA22CC44.
REQ-028 Bypass and dual read: write addr 5, data 0x12345678, be 1111 with rd_addr0=5 and rd_addr1=5 in the same cycle -> both ports show 0x12345678 combinationally; next cycle unchanged.
REQ-029 Clear sweep: fill regs 0..7 with 0xFFFFFFFF, pulse clr_req -> clr_busy high for 8 cycles, writes during the sweep dropped, clr_done pulses once, then all regs read 0.
REQ-030 Boundaries: DEPTH=6 -> write addr 7 is dropped and rd_addr 7 reads 0; ZERO_REG=1 -> write 0x5 to addr 0 still reads 0.
REQ-031 Reset mid-sweep: assert reset_n=0 at sweep index 3 -> all regs 0, clr_busy=0, FSM IDLE; after release, write addr 2 = 0x9 reads back 0x9.
